// File: rtl/writeback_pkg.sv
// Shared writeback definitions: datapath widths, RV32 opcodes and load funct3 codes.
`default_nettype none
package writeback_pkg;
  localparam int XLEN  = 32;
  localparam int XADDR = 5;

  localparam logic [6:0] LUI_OP   = 7'b0110111;
  localparam logic [6:0] AUIPC_OP = 7'b0010111;
  localparam logic [6:0] JAL_OP   = 7'b1101111;
  localparam logic [6:0] JALR_OP  = 7'b1100111;
  localparam logic [6:0] I_OP     = 7'b0010011;
  localparam logic [6:0] L_OP     = 7'b0000011;
  localparam logic [6:0] S_OP     = 7'b0100011;
  localparam logic [6:0] B_OP     = 7'b1100011;
  localparam logic [6:0] R_OP     = 7'b0110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage
`default_nettype wire

// File: rtl/load_align.sv
// Load data formatting: lane extraction, sign/zero extension and
// misalignment / illegal-size fault detection.
`default_nettype none
module load_align
  import writeback_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        fault
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr, 3'b000} +: 8];
  assign half_sel = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'b0, byte_sel};
      F3_LH: begin
        data  = {{16{half_sel[15]}}, half_sel};
        fault = addr[0];
      end
      F3_LHU: begin
        data  = {16'b0, half_sel};
        fault = addr[0];
      end
      F3_LW: begin
        data  = word;
        fault = |addr;
      end
      default: fault = 1'b1;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/writeback.sv
// Writeback stage: turns memory-stage results and load responses into
// single-cycle register-file write (or load-fault) pulses.
`default_nettype none
module writeback #(
  parameter int XLEN  = writeback_pkg::XLEN,
  parameter int XADDR = writeback_pkg::XADDR
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic [XLEN-1:0]  i_result,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_mem_rvalid,
  input  logic [XLEN-1:0]  i_mem_rdata,
  output logic [XADDR-1:0] or_rd_addr,
  output logic [XLEN-1:0]  or_rd_data,
  output logic             or_wr_en,
  output logic             or_load_fault
);
  import writeback_pkg::*;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [XADDR-1:0] ld_rd, ld_rd_nx;
  logic [2:0]       ld_funct3, ld_funct3_nx;
  logic [1:0]       ld_addr, ld_addr_nx;
  logic [XADDR-1:0] rd_addr_nx;
  logic [XLEN-1:0]  rd_data_nx;
  logic             wr_en_nx;
  logic             fault_nx;
  logic             op_writes;
  logic [XLEN-1:0]  op_data;
  logic [31:0]      align_data;
  logic             align_fault;

  load_align u_load_align (
    .funct3 (ld_funct3),
    .addr   (ld_addr),
    .word   (i_mem_rdata[31:0]),
    .data   (align_data),
    .fault  (align_fault)
  );

  assign o_ready = (state == IDLE);

  always_comb begin
    op_writes = 1'b1;
    op_data   = i_result;
    case (i_opcode)
      LUI_OP:                    op_data = i_imm;
      AUIPC_OP, R_OP, I_OP:      op_data = i_result;
      JAL_OP, JALR_OP:           op_data = i_pc + XLEN'(4);
      default:                   op_writes = 1'b0;
    endcase
  end

  always_comb begin
    state_nx     = state;
    ld_rd_nx     = ld_rd;
    ld_funct3_nx = ld_funct3;
    ld_addr_nx   = ld_addr;
    rd_addr_nx   = or_rd_addr;
    rd_data_nx   = or_rd_data;
    wr_en_nx     = 1'b0;
    fault_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          if (i_opcode == L_OP) begin
            ld_rd_nx     = i_rd_addr;
            ld_funct3_nx = i_funct3;
            ld_addr_nx   = i_result[1:0];
            state_nx     = WAIT_LOAD;
          end else begin
            rd_addr_nx = i_rd_addr;
            wr_en_nx   = op_writes && (i_rd_addr != '0);
            if (op_writes) rd_data_nx = op_data;
          end
        end
      end
      WAIT_LOAD: begin
        if (i_mem_rvalid) begin
          rd_addr_nx = ld_rd;
          state_nx   = IDLE;
          if (align_fault) begin
            fault_nx = 1'b1;
          end else begin
            wr_en_nx   = (ld_rd != '0);
            rd_data_nx = XLEN'(align_data);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      ld_rd         <= '0;
      ld_funct3     <= '0;
      ld_addr       <= '0;
      or_rd_addr    <= '0;
      or_rd_data    <= '0;
      or_wr_en      <= 1'b0;
      or_load_fault <= 1'b0;
    end else begin
      state         <= state_nx;
      ld_rd         <= ld_rd_nx;
      ld_funct3     <= ld_funct3_nx;
      ld_addr       <= ld_addr_nx;
      or_rd_addr    <= rd_addr_nx;
      or_rd_data    <= rd_data_nx;
      or_wr_en      <= wr_en_nx;
      or_load_fault <= fault_nx;
    end
  end
endmodule
`default_nettype wire

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter: XLEN, 32, datapath width; equals the shared header XLEN.
REQ-002 Parameter: XADDR, 5, register address width; equals the shared header XADDR.
REQ-003 Port: i_clk  in  1  CPU clock; the block has exactly one clock and all state changes on its rising edge.
REQ-004 Port: i_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 Port: i_valid  in  1  memory-stage result valid.
REQ-006 Port: o_ready  out  1  block can accept a result; combinational from state.
REQ-007 Port: i_opcode  in  7  instruction opcode.
REQ-008 Port: i_funct3  in  3  funct3 (load size/sign).
REQ-009 Port: i_rd_addr  in  XADDR  destination register.
REQ-010 Port: i_result  in  XLEN  ALU result; effective address for loads.
REQ-011 Port: i_imm  in  XLEN  decoded immediate.
REQ-012 Port: i_pc  in  XLEN  instruction PC.
REQ-013 Port: i_mem_rvalid  in  1  data-memory read response valid.
REQ-014 Port: i_mem_rdata  in  XLEN  aligned 32-bit read word.
REQ-015 Port: or_rd_addr  out  XADDR  register-file write address.
REQ-016 Port: or_rd_data  out  XLEN  register-file write data.
REQ-017 Port: or_wr_en  out  1  register-file write enable; one-cycle pulse.
REQ-018 Port: or_load_fault  out  1  one-cycle pulse on misaligned or illegal-funct3 load.

Function
REQ-019 Accept occurs when i_valid and o_ready are both 1 on a rising edge.
REQ-020 States are IDLE and WAIT_LOAD; o_ready = 1 in IDLE and 0 in WAIT_LOAD.
REQ-021 Non-load accepted in IDLE: on the next edge, or_rd_addr <= i_rd_addr and or_wr_en <= 1 if the opcode writes and rd != 0; the state stays IDLE. Latency is 1 cycle.
REQ-022 Write data by opcode:
- LUI: i_imm.
- AUIPC, R_OP, I_OP: i_result.
- JAL, JALR: i_pc + 4, mod 2^32.
- S_OP, B_OP, unknown opcodes: no write.
REQ-023 Load accepted in IDLE: capture rd, funct3 and i_result[1:0], then go to WAIT_LOAD; or_wr_en stays 0.
REQ-024 WAIT_LOAD with i_mem_rvalid = 1: format the data, write on the next edge (rd != 0 rule applies), and return to IDLE. WAIT_LOAD holds indefinitely while i_mem_rvalid = 0.
REQ-025 Load formatting (byte lane = addr[1:0]):
- LB/LBU: byte lane sign-/zero-extended.
- LH/LHU: halfword at addr[1]*16, sign-/zero-extended.
- LW: full word.
REQ-026 Load faults: LH/LHU with addr[0] = 1, LW with addr[1:0] != 0, or funct3 in {011, 110, 111} produce no write and pulse or_load_fault in the write cycle.
REQ-027 i_mem_rvalid is ignored in IDLE, including in the cycle a load is accepted.
REQ-028 or_wr_en and or_load_fault are 0 in every cycle except the single write/fault cycle.

Reset
REQ-029 Asserting i_rst_n low immediately forces state IDLE and clears or_rd_addr, or_rd_data, or_wr_en and or_load_fault to 0.
REQ-030 Reset during WAIT_LOAD abandons the pending load; a later i_mem_rvalid produces no write.

Structure
REQ-031 Opcode constants (LUI_OP, AUIPC_OP, JAL_OP, JALR_OP, I_OP, L_OP, S_OP, B_OP, R_OP), XLEN and XADDR come from the shared header; state encodings stay local.
REQ-032 One sub-module, load_align, performs the combinational byte/half extraction, extension and fault detection.

Verification
REQ-033 R_OP, rd = 5, i_result = 0x0000_1234, accepted -> next cycle or_wr_en = 1, or_rd_addr = 5, or_rd_data = 0x0000_1234.
REQ-034 JAL, rd = 1, i_pc = 0xFFFF_FFFC -> or_rd_data = 0x0000_0000 (wrap). The same with rd = 0 -> or_wr_en stays 0.
REQ-035 LB at addr 0x...3, response 0x80AA_BBCC after 3 cycles -> o_ready = 0 for 3 cycles, then or_rd_data = 0xFFFF_FF80. The same as LBU -> 0x0000_0080.
REQ-036 LW at addr 0x...2 -> or_load_fault pulses, or_wr_en = 0.
REQ-037 LH accepted, reset pulsed in WAIT_LOAD, then i_mem_rvalid = 1 -> no write, o_ready = 1.
REQ-038 i_mem_rvalid = 1 in the same cycle an LHU is accepted -> ignored; the next response, 0x1234_8765 at addr[1] = 1, gives or_rd_data = 0x0000_1234.
